// File: rtl/sum_acc_pkg.sv
// Shared definitions for the sum accumulator: FSM state encoding and default widths.
package sum_acc_pkg;

    localparam int SUM_W_D = 7;
    localparam int ACC_W_D = 12;
    localparam int CNT_W_D = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sum_accumulator.sv
// Accumulates a programmed burst of adder sums and presents total, count and
// sticky overflow on a valid/ready result port.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int SUM_W = SUM_W_D,
    parameter int ACC_W = ACC_W_D,
    parameter int CNT_W = CNT_W_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             busy
);

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] len_q;
    logic             ovf_q;
    logic [ACC_W-1:0] out_acc_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_ovf_q;

    logic [ACC_W-1:0] acc_d;
    logic             carry_d;
    logic             ovf_d;
    logic [CNT_W-1:0] count_d;
    logic             last_d;

    // Next accumulator value with the carry out of the MSB kept separately.
    always_comb begin
        {carry_d, acc_d} = {1'b0, acc_q} + (ACC_W + 1)'(in_sum);
        ovf_d            = ovf_q | carry_d;
        count_d          = count_q + CNT_W'(1);
        last_d           = (count_q == (len_q - CNT_W'(1)));
    end

    // Burst FSM together with accumulator, counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (len != '0)) begin
                        state_q <= ACCUM;
                        len_q   <= len;
                        acc_q   <= '0;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_q   <= acc_d;
                        ovf_q   <= ovf_d;
                        count_q <= count_d;
                        if (last_d) begin
                            state_q     <= DONE;
                            out_acc_q   <= acc_d;
                            out_count_q <= count_d;
                            out_ovf_q   <= ovf_d;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags depend on the state register only, never on inputs.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_acc   = out_acc_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule
